// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, FSM state encoding and a
// parity helper, used by both the receive and transmit paths.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PAR       = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } uart_state_e;

   // Parity bit a well-formed frame carries, given the XOR of its data bits.
   function automatic logic parity_bit(input logic data_xor, input int mode);
      return (mode == PARITY_ODD) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: an OSR-tick counter, a 2-of-3
// majority vote around mid-bit, and a bit_done strobe on the deciding tick.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OSR = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_rx_s,
   input  logic i_start,     // this tick is tick 0 of a start bit
   input  logic i_run,       // a frame is in progress
   output logic o_bit_done,  // deciding tick of the current bit
   output logic o_bit_val    // majority value, valid with o_bit_done
);

   localparam int CW = $clog2(OSR);
   localparam logic [CW-1:0] T_LAST = CW'(OSR - 1);
   localparam logic [CW-1:0] T_A    = CW'(OSR / 2 - 1);
   localparam logic [CW-1:0] T_B    = CW'(OSR / 2);
   localparam logic [CW-1:0] T_C    = CW'(OSR / 2 + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    smp_q, smp_d;

   // Tick counter and capture of the first two majority samples.
   always_comb begin
      cnt_d = cnt_q;
      smp_d = smp_q;
      if (i_en) begin
         if (i_start) begin
            cnt_d = CW'(1);
         end else if (i_run) begin
            cnt_d = (cnt_q == T_LAST) ? '0 : cnt_q + 1'b1;
         end else begin
            cnt_d = '0;
         end
         if (i_run && (cnt_q == T_A)) smp_d[0] = i_rx_s;
         if (i_run && (cnt_q == T_B)) smp_d[1] = i_rx_s;
      end
   end

   // Counter and sample registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
         smp_q <= 2'b11;
      end else begin
         cnt_q <= cnt_d;
         smp_q <= smp_d;
      end
   end

   // The third sample is the live line on the deciding tick.
   assign o_bit_done = i_en & i_run & (cnt_q == T_C);
   assign o_bit_val  = (smp_q[0] & smp_q[1]) | (smp_q[0] & i_rx_s) | (smp_q[1] & i_rx_s);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronizes the line, walks start/data/parity/stop
// bits, and presents each word with parity, framing and break flags.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int OSR       = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_break,
   output logic                 o_busy
);

   if ((OSR < 4) || ((OSR % 2) != 0)) begin : g_bad_osr
      $fatal(1, "uart_rx_frame: OSR must be even and at least 4");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $fatal(1, "uart_rx_frame: DATA_BITS must be in 5..9");
   end
   if ((PARITY != PARITY_NONE) && (PARITY != PARITY_ODD) && (PARITY != PARITY_EVEN)) begin : g_bad_parity
      $fatal(1, "uart_rx_frame: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $fatal(1, "uart_rx_frame: STOP_BITS must be 1 or 2");
   end

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   // Handshake: o_valid is a one-cycle strobe with no back-pressure; o_data and
   // the three error flags are stable from that cycle until the next strobe.

   logic [1:0]           sync_q;
   logic                 rx_s;
   uart_state_e          state_q, state_d;
   logic [3:0]           bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 all_low_q, all_low_d;
   logic                 perr_acc_q, perr_acc_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 brk_q, brk_d;
   logic                 smp_start, smp_run;
   logic                 bit_done, bit_val;
   logic                 ferr_now, low_now;

   // Two-flop synchronizer on the asynchronous line, idling high.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], i_rx};
   end
   assign rx_s = sync_q[1];

   uart_rx_sampler #(.OSR(OSR)) u_sampler (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en),
      .i_rx_s     (rx_s),
      .i_start    (smp_start),
      .i_run      (smp_run),
      .o_bit_done (bit_done),
      .o_bit_val  (bit_val)
   );

   // Frame FSM next state, shift register and output capture.
   always_comb begin
      state_d    = state_q;
      bcnt_d     = bcnt_q;
      shift_d    = shift_q;
      all_low_d  = all_low_q;
      perr_acc_d = perr_acc_q;
      ferr_acc_d = ferr_acc_q;
      data_d     = data_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      brk_d      = brk_q;
      valid_d    = 1'b0;
      smp_start  = 1'b0;
      smp_run    = 1'b0;
      ferr_now   = ferr_acc_q | ~bit_val;
      low_now    = all_low_q & ~bit_val;
      case (state_q)
         ST_IDLE: begin
            if (i_en && !rx_s) begin
               smp_start  = 1'b1;
               state_d    = ST_START;
               bcnt_d     = '0;
               all_low_d  = 1'b1;
               perr_acc_d = 1'b0;
               ferr_acc_d = 1'b0;
            end
         end
         ST_START: begin
            smp_run = 1'b1;
            if (bit_done) state_d = bit_val ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            smp_run = 1'b1;
            if (bit_done) begin
               shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
               all_low_d = low_now;
               if (bcnt_q == LAST_DATA) begin
                  bcnt_d  = '0;
                  state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         end
         ST_PAR: begin
            smp_run = 1'b1;
            if (bit_done) begin
               perr_acc_d = (bit_val != parity_bit(^shift_q, PARITY));
               all_low_d  = low_now;
               state_d    = ST_STOP;
            end
         end
         ST_STOP: begin
            smp_run = 1'b1;
            if (bit_done) begin
               if (bcnt_q == LAST_STOP) begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
                  perr_d  = perr_acc_q;
                  ferr_d  = ferr_now;
                  brk_d   = ferr_now & low_now;
                  bcnt_d  = '0;
                  state_d = ferr_now ? ST_WAIT_IDLE : ST_IDLE;
               end else begin
                  ferr_acc_d = ferr_now;
                  all_low_d  = low_now;
                  bcnt_d     = bcnt_q + 1'b1;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (i_en && rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Frame state and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         bcnt_q     <= '0;
         shift_q    <= '0;
         all_low_q  <= 1'b0;
         perr_acc_q <= 1'b0;
         ferr_acc_q <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bcnt_q     <= bcnt_d;
         shift_q    <= shift_d;
         all_low_q  <= all_low_d;
         perr_acc_q <= perr_acc_d;
         ferr_acc_q <= ferr_acc_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_parity_err = perr_q;
   assign o_frame_err  = ferr_q;
   assign o_break      = brk_q;
   assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 and an 8E1 receiver, each on its own line,
// fed by a fractional-baud serial driver and checked against a frame model.
module tb_uart_rx_frame;
   import uart_pkg::*;

   localparam int OSR          = 16;
   localparam int DW           = 8;
   localparam int CLK_PER_TICK = 4;
   localparam int BIT_CLKS     = OSR * CLK_PER_TICK;
   localparam int W            = DW + 3;
   localparam int PER_NOM      = 6400;   // bit period in 1/100 clock
   localparam int PER_FAST     = 6208;   // +3% baud
   localparam int PER_SLOW     = 6592;   // -3% baud

   logic clk = 1'b0;
   logic rst, en, rx_n, rx_e;
   logic [DW-1:0] n_data, e_data;
   logic n_valid, n_perr, n_ferr, n_brk, n_busy;
   logic e_valid, e_perr, e_ferr, e_brk, e_busy;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_n_q[$];
   logic [W-1:0] exp_e_q[$];
   logic [W-1:0] last_n = '0;
   logic [W-1:0] last_e = '0;

   uart_rx_frame #(.OSR(OSR), .DATA_BITS(DW), .PARITY(PARITY_NONE), .STOP_BITS(1)) dut_n (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx_n),
      .o_data(n_data), .o_valid(n_valid), .o_parity_err(n_perr),
      .o_frame_err(n_ferr), .o_break(n_brk), .o_busy(n_busy)
   );

   uart_rx_frame #(.OSR(OSR), .DATA_BITS(DW), .PARITY(PARITY_EVEN), .STOP_BITS(1)) dut_e (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx_e),
      .o_data(e_data), .o_valid(e_valid), .o_parity_err(e_perr),
      .o_frame_err(e_ferr), .o_break(e_brk), .o_busy(e_busy)
   );

   // Clock, cycle counter and oversample tick.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      en = 1'b0;
      forever begin
         @(negedge clk);
         en = ((cyc % CLK_PER_TICK) == 0);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: what a receiver must report for one frame, from the framing rules.
   function automatic logic [W-1:0] model(input logic [7:0] d, input int pm, input logic pbit, input logic s1);
      logic perr, ferr, brk, want;
      want = (pm == PARITY_ODD) ? ~(^d) : (^d);
      perr = (pm != PARITY_NONE) && (pbit != want);
      ferr = ~s1;
      brk  = ferr && (d == 8'h00) && ((pm == PARITY_NONE) || (pbit == 1'b0));
      return {brk, ferr, perr, d};
   endfunction

   // Scoreboard: every o_valid must match the oldest expected frame.
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (n_valid) begin
         check("n_valid_was_expected", (exp_n_q.size() != 0), 1);
         if (exp_n_q.size() != 0) begin
            e = exp_n_q.pop_front();
            check("n_frame", {n_brk, n_ferr, n_perr, n_data}, e);
            last_n = e;
         end
      end
      if (e_valid) begin
         check("e_valid_was_expected", (exp_e_q.size() != 0), 1);
         if (exp_e_q.size() != 0) begin
            e = exp_e_q.pop_front();
            check("e_frame", {e_brk, e_ferr, e_perr, e_data}, e);
            last_e = e;
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_clocks(input int n);
      int t0;
      t0 = cyc;
      wait_until(t0 + n);
   endtask

   task automatic drive(input bit line_e, input logic v);
      if (line_e) rx_e = v;
      else        rx_n = v;
   endtask

   // Serial driver with fractional bit period and optional one-tick glitches.
   task automatic send_bits(input bit line_e, input logic [15:0] bits, input int nb,
                            input int per, input int gmask);
      int c0, bs;
      c0 = cyc;
      for (int k = 0; k < nb; k++) begin
         bs = c0 + (k * per) / 100;
         drive(line_e, bits[k]);
         if (gmask[k]) begin
            wait_until(bs + 7 * CLK_PER_TICK);
            drive(line_e, ~bits[k]);
            wait_until(bs + 8 * CLK_PER_TICK);
            drive(line_e, bits[k]);
         end
         wait_until(c0 + ((k + 1) * per) / 100);
      end
   endtask

   task automatic send_frame(input bit line_e, input logic [7:0] d, input logic pbit,
                             input logic s1, input int per, input int gmask, input int gap);
      logic [15:0] bits;
      int nb, pm;
      pm = line_e ? PARITY_EVEN : PARITY_NONE;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
      nb = 9;
      if (pm != PARITY_NONE) begin
         bits[nb] = pbit;
         nb++;
      end
      bits[nb] = s1;
      nb++;
      if (line_e) exp_e_q.push_back(model(d, pm, pbit, s1));
      else        exp_n_q.push_back(model(d, pm, pbit, s1));
      send_bits(line_e, bits, nb, per, gmask);
      drive(line_e, 1'b1);
      wait_clocks(gap * BIT_CLKS);
   endtask

   task automatic drain(input int budget);
      int t0;
      t0 = cyc;
      while (((exp_n_q.size() != 0) || (exp_e_q.size() != 0)) && (cyc < t0 + budget))
         @(negedge clk);
      check("n_frames_outstanding", exp_n_q.size(), 0);
      check("e_frames_outstanding", exp_e_q.size(), 0);
      exp_n_q.delete();
      exp_e_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_n_outputs"}, {n_data, n_valid, n_perr, n_ferr, n_brk, n_busy}, 0);
      check({tag, "_e_outputs"}, {e_data, e_valid, e_perr, e_ferr, e_brk, e_busy}, 0);
   endtask

   // Directed and randomized stimulus.
   initial begin
      int pers[3];
      int per;
      logic [7:0] d;
      logic pbit, s1;
      pers[0] = PER_FAST;
      pers[1] = PER_NOM;
      pers[2] = PER_SLOW;
      rst  = 1'b1;
      rx_n = 1'b1;
      rx_e = 1'b1;
      wait_clocks(5);
      check_reset_outputs("reset");
      rst = 1'b0;
      wait_clocks(2 * BIT_CLKS);

      // 8N1 byte at exact baud
      send_frame(1'b0, 8'hA5, 1'b0, 1'b1, PER_NOM, 0, 2);
      drain(4 * BIT_CLKS);

      // 8E1 parity error, then correct parity
      send_frame(1'b1, 8'h03, 1'b1, 1'b1, PER_NOM, 0, 2);
      send_frame(1'b1, 8'h03, 1'b0, 1'b1, PER_NOM, 0, 2);
      drain(4 * BIT_CLKS);

      // false start: low for five ticks
      rx_n = 1'b0;
      wait_clocks(5 * CLK_PER_TICK - 8);
      check("false_start_busy_high", n_busy, 1);
      wait_clocks(8);
      rx_n = 1'b1;
      wait_clocks(2 * BIT_CLKS);
      check("false_start_busy_low", n_busy, 0);
      check("false_start_outputs_held", {n_brk, n_ferr, n_perr, n_data}, last_n);
      send_frame(1'b0, 8'h5A, 1'b0, 1'b1, PER_NOM, 0, 2);
      drain(4 * BIT_CLKS);

      // held break for three frame times yields exactly one frame
      exp_n_q.push_back(model(8'h00, PARITY_NONE, 1'b0, 1'b0));
      rx_n = 1'b0;
      wait_clocks(30 * BIT_CLKS);
      check("break_busy_while_held", n_busy, 1);
      rx_n = 1'b1;
      wait_clocks(2 * BIT_CLKS);
      check("break_busy_after_release", n_busy, 0);
      send_frame(1'b0, 8'h81, 1'b0, 1'b1, PER_NOM, 0, 2);
      drain(4 * BIT_CLKS);

      // back-to-back frames with glitches on data bits 2 and 5, three baud rates
      for (int p = 0; p < 3; p++) begin
         send_frame(1'b0, 8'h11, 1'b0, 1'b1, pers[p], (1 << 3) | (1 << 6), 0);
         send_frame(1'b0, 8'h22, 1'b0, 1'b1, pers[p], (1 << 3) | (1 << 6), 0);
         send_frame(1'b0, 8'h33, 1'b0, 1'b1, pers[p], (1 << 3) | (1 << 6), 2);
         drain(4 * BIT_CLKS);
      end

      // reset in the middle of data bit 4 aborts the frame
      send_bits(1'b0, 16'b1111_1111_1111_1000, 5, PER_NOM, 0);
      rx_n = 1'b1;
      wait_clocks(BIT_CLKS / 2);
      check("abort_busy_before_reset", n_busy, 1);
      rst  = 1'b1;
      wait_clocks(3);
      check_reset_outputs("midframe_reset");
      last_n = '0;
      last_e = '0;
      rst = 1'b0;
      wait_clocks(2 * BIT_CLKS);
      check("abort_no_frame_after_reset", n_busy, 0);
      send_frame(1'b0, 8'hC3, 1'b0, 1'b1, PER_NOM, 0, 2);
      drain(4 * BIT_CLKS);

      // randomized frames on both receivers
      for (int i = 0; i < 12; i++) begin
         d   = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0) d = 8'h00;
         s1  = ($urandom_range(0, 4) != 0);
         per = pers[$urandom_range(0, 2)];
         send_frame(1'b0, d, 1'b0, s1, per, 0, 1);
      end
      for (int i = 0; i < 12; i++) begin
         d    = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0) d = 8'h00;
         pbit = (^d) ^ ($urandom_range(0, 3) == 0);
         s1   = ($urandom_range(0, 4) != 0);
         per  = pers[$urandom_range(0, 2)];
         send_frame(1'b1, d, pbit, s1, per, 0, 1);
      end
      drain(4 * BIT_CLKS);
      check("final_n_idle", n_busy, 0);
      check("final_e_idle", e_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 SHALL have parameter OSR, default 16, oversample ticks per bit; legal values are even and >= 4.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range is 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values are 1 or 2.
REQ-005 SHALL have port i_clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port i_en, input, 1 bit: oversample tick, a clock enable pulsing at OSR x baud.
REQ-008 SHALL have port i_rx, input, 1 bit: serial line, asynchronous, idle high.
REQ-009 SHALL have port o_data, output, DATA_BITS wide: received word, LSB first on the line.
REQ-010 SHALL have port o_valid, output, 1 bit: single-i_clk pulse at frame end.
REQ-011 SHALL have port o_parity_err, output, 1 bit: qualified by o_valid.
REQ-012 SHALL have port o_frame_err, output, 1 bit: a stop bit sampled low; qualified by o_valid.
REQ-013 SHALL have port o_break, output, 1 bit: all data, parity and stop bits sampled low; qualified by o_valid.
REQ-014 SHALL have port o_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 SHALL pass i_rx through a 2-flop synchronizer reset to 1; all logic uses the synchronized line rx_s.
REQ-016 SHALL advance all state only on i_clk cycles with i_en=1; otherwise state holds.
REQ-017 SHALL implement states IDLE, START, DATA, PAR, STOP and WAIT_IDLE.
REQ-018 In IDLE, the first tick with rx_s=0 SHALL be tick 0 of the start bit; the tick counter clears and the state goes to START.
REQ-019 SHALL count each bit as OSR ticks (0..OSR-1) using a counter of width $clog2(OSR) that wraps to 0 at OSR-1.
REQ-020 SHALL decide each bit by a 2-of-3 majority of rx_s at ticks OSR/2-1, OSR/2 and OSR/2+1; the decision is made at tick OSR/2+1.
REQ-021 In START, a majority of 1 SHALL be treated as a false start: return to IDLE with no o_valid and o_busy falling.
REQ-022 DATA SHALL shift in DATA_BITS bits LSB first, then go to PAR if PARITY != 0, else to STOP.
REQ-023 PAR SHALL compare the received bit with the computed parity (odd: XOR of data is inverted; even: XOR of data); a mismatch sets the parity error.
REQ-024 STOP SHALL sample STOP_BITS bits; any stop bit sampled 0 sets the frame error.
REQ-025 SHALL raise o_valid for exactly one i_clk cycle, the cycle after the tick deciding the last stop bit; it does not wait out the remainder of that bit.
REQ-026 o_data and all error flags SHALL update together with o_valid and hold until the next o_valid.
REQ-027 o_break SHALL assert only together with o_frame_err; o_parity_err SHALL be 0 when PARITY=0.
REQ-028 After a frame error the block SHALL enter WAIT_IDLE and return to IDLE only after a tick with rx_s=1, so a held break produces exactly one frame.
REQ-029 After a clean frame the block SHALL return to IDLE and accept a start edge on the very next tick (back-to-back frames).
REQ-030 A glitch shorter than 2 ticks inside any bit SHALL NOT change that bit's decision.

Reset
REQ-031 On i_rst=1 the block SHALL asynchronously set: state IDLE, counters 0, synchronizer flops 1, o_data 0, o_valid 0, all error flags 0, o_busy 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no o_valid; after release, the block rearms on the next falling edge.

Structure
REQ-033 Package uart_pkg SHALL hold the PARITY_NONE, PARITY_ODD and PARITY_EVEN constants and the state encoding, shared with the TX path.
REQ-034 Sub-module uart_rx_sampler SHALL contain the tick counter, the 3-sample majority vote and a bit_done strobe; uart_rx_frame SHALL contain the FSM and the shift register.
REQ-035 Parameter legality SHALL be checked at elaboration; an illegal value is a fatal error.

Verification
REQ-036 OSR=16, 8N1, byte 0xA5 at exact baud -> one o_valid with o_data=0xA5, all error flags 0.
REQ-037 OSR=16, 8E1: send 0x03 with parity bit 1 -> o_valid with o_parity_err=1 and o_data=0x03; then send 0x03 with parity 0 -> no error.
REQ-038 Line low for 5 ticks then high -> no o_valid, o_busy returns to 0, and the next valid frame 0x5A is received correctly.
REQ-039 Line held low for 3 frame times, then high -> exactly one o_valid with o_data=0x00, o_frame_err=1, o_break=1; the next frame 0x81 is received cleanly.
REQ-040 Back-to-back frames 0x11, 0x22, 0x33 with 1-tick glitches at tick 7 of bits 2/5 -> three o_valid pulses with correct data; also send at +3%/-3% baud -> same results.
REQ-041 i_rst pulsed at DATA bit 4 -> no o_valid and all outputs at reset values; a following frame 0xC3 is received correctly.
